// File: rtl/rv_fetch_pkg.sv
// ---------------------------------------------------------------------------
// rv_fetch_pkg
//   Types and constants shared by the instruction fetch unit and its buffer.
//   - XLEN          : PC / address width
//   - NOP_INST      : instruction shown to decode when nothing is buffered
//   - INST_BYTES    : size of one fetch (sequential PC increment)
//   - fetch_entry_t : one buffered instruction together with its PC
//   - fetch_state_e : fetch FSM states
//   - pc_align      : clears the low address bits of a fetch target
// ---------------------------------------------------------------------------
package rv_fetch_pkg;

    localparam int          XLEN       = 64;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam int          INST_BYTES = 4;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fetch_state_e;

    // Force a fetch target onto an instruction boundary.
    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
        return pc & ~(XLEN'(INST_BYTES - 1));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO holding fetched instructions.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     flush_i       : empty the FIFO (wins over a push in the same cycle)
//     push_i        : write push_data_i at the tail
//     push_data_i   : entry to write
//     pop_i         : drop the head entry (ignored when empty)
//     count_o       : number of valid entries
//     head_o        : oldest entry (undefined content when count_o == 0)
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [WIDTH-1:0]           head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop: a full FIFO still accepts a push when it pops in the same cycle.
    always_comb begin
        do_pop_s  = pop_i && (count_q != '0);
        do_push_s = push_i && ((count_q != FULL_CNT) || do_pop_s);
    end

    // Storage, pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction fetch stage with a prefetch buffer in front of decode.
//   Issues sequential 4-byte fetches to a variable-latency, in-order imem,
//   buffers returned words with their PC and hands them to decode over
//   valid/ready. A redirect flushes the buffer and discards every response
//   that belongs to requests issued before (or in) the redirect cycle.
//   Ports:
//     clk, rst                        : clock, asynchronous active-low reset
//     imem_req_valid/ready/addr       : fetch request channel
//     imem_rsp_valid/data             : in-order instruction return
//     redirect_valid/pc               : restart fetch at a new target
//     inst_valid/ready, inst, inst_pc : buffered instruction to decode
// ---------------------------------------------------------------------------
module if_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(INST_BYTES);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0] fifo_count_s;
    logic [SUM_W-1:0] credit_used_s;
    fetch_entry_t     head_s;
    fetch_entry_t     push_entry_s;
    logic             req_hs_s;
    logic             rsp_keep_s;
    logic             pop_s;

    // Handshakes and outputs. Buffer slots are reserved at request time, so
    // a returning response can never find the FIFO full.
    always_comb begin
        credit_used_s  = SUM_W'(outstanding_q) + SUM_W'(fifo_count_s);
        imem_req_valid = (state_q == S_RUN) && (credit_used_s < SUM_W'(FIFO_DEPTH));
        imem_req_addr  = fetch_pc_q;
        req_hs_s       = imem_req_valid && imem_req_ready;
        rsp_keep_s     = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
        inst_valid     = (fifo_count_s != '0);
        pop_s          = inst_valid && inst_ready;
        push_entry_s.inst = imem_rsp_data;
        push_entry_s.pc   = rsp_pc_q;
        if (inst_valid) begin
            inst    = head_s.inst;
            inst_pc = head_s.pc;
        end else begin
            inst    = NOP_INST;
            inst_pc = '0;
        end
    end

    // Next-state for the FSM, PCs and request bookkeeping.
    always_comb begin
        case (state_q)
            S_IDLE:  state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase

        outstanding_d = outstanding_q + CNT_W'(req_hs_s) - CNT_W'(imem_rsp_valid);

        if (redirect_valid) begin
            fetch_pc_d = pc_align(redirect_pc);
            rsp_pc_d   = pc_align(redirect_pc);
            // Everything still owed by imem after this cycle belongs to the old stream.
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_hs_s) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (rsp_keep_s) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
            end else begin
                rsp_pc_d = rsp_pc_q;
            end
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // FSM state and fetch bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fetch_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .flush_i     (redirect_valid),
        .push_i      (rsp_keep_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .count_o     (fifo_count_s),
        .head_o      (head_s)
    );

endmodule
